// File: rtl/load_sequencer_if.sv
// Purpose: groups the CPU-side, decoder-side and status signals of load_sequencer.
// Signals:
//   Start              load request pulse (driver -> sequencer)
//   CPU_Data/Valid     CPU word and its valid (driver -> sequencer)
//   CPU_Ready          word accepted when CPU_Valid && CPU_Ready (sequencer -> driver)
//   Dec_Bus            word presented to the decoder
//   Dec_Loading_Enable decoder enable level
//   Dec_Done_Packet    decoder consumed current word (pulse)
//   Dec_Done_Loading   decoder finished all rows (pulse)
//   Solver_Start       one-cycle start pulse to the ODE solver core
//   Busy/Error         status; Error is sticky until the next Start
//   Words_Loaded       saturating count of words placed on Dec_Bus since Start
interface load_sequencer_if;
    logic        Start;
    logic [31:0] CPU_Data;
    logic        CPU_Valid;
    logic        CPU_Ready;
    logic [31:0] Dec_Bus;
    logic        Dec_Loading_Enable;
    logic        Dec_Done_Packet;
    logic        Dec_Done_Loading;
    logic        Solver_Start;
    logic        Busy;
    logic        Error;
    logic [15:0] Words_Loaded;

    // Sequencer side
    modport slave (
        input  Start, CPU_Data, CPU_Valid, Dec_Done_Packet, Dec_Done_Loading,
        output CPU_Ready, Dec_Bus, Dec_Loading_Enable, Solver_Start, Busy, Error,
               Words_Loaded
    );

    // CPU / decoder / controller side
    modport master (
        output Start, CPU_Data, CPU_Valid, Dec_Done_Packet, Dec_Done_Loading,
        input  CPU_Ready, Dec_Bus, Dec_Loading_Enable, Solver_Start, Busy, Error,
               Words_Loaded
    );
endinterface

// File: rtl/load_sequencer.sv
// Purpose: buffers CPU words in a small FIFO, presents the two header words to the
// decoder with fixed timing (word0 two cycles, word1 one cycle), then streams one
// word per decoder packet handshake. Issues a solver start pulse on completion and
// flags header/stream underrun and stalled transfers.
// Ports:
//   CLK    clock, all state on rising edge
//   RST    asynchronous active-low reset
//   bus    load_sequencer_if.slave (CPU, decoder and status signals)
// Parameters:
//   FIFO_DEPTH      CPU word buffer depth (power of 2, >= 2)
//   TIMEOUT_CYCLES  max STREAM cycles without decoder activity
module load_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    load_sequencer_if.slave  bus
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HDR0,
        S_HDR1,
        S_STREAM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;

    logic            r_hdr_phase;
    logic            w_hdr_phase_nxt;
    logic [TW-1:0]   r_timeout;
    logic [TW-1:0]   w_timeout_nxt;

    logic            w_push;
    logic            w_pop;
    logic            w_start_acc;
    logic            w_discard;
    logic            w_clear;
    logic            w_ready_nxt;

    logic            r_cpu_ready;
    logic [DW-1:0]   r_dec_bus;
    logic            r_dec_en;
    logic            r_solver_start;
    logic            r_busy;
    logic            r_error;
    logic [NW-1:0]   r_words;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_hdr_phase <= 1'b0;
            r_timeout   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hdr_phase <= w_hdr_phase_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Next state, FIFO control and next-cycle output values
    always_comb begin
        w_state_nxt     = r_state;
        w_hdr_phase_nxt = r_hdr_phase;
        w_timeout_nxt   = r_timeout;
        w_pop           = 1'b0;
        w_start_acc     = 1'b0;
        w_discard       = 1'b0;

        unique case (r_state)
            S_IDLE, S_ERROR: begin
                if (bus.Start) begin
                    w_start_acc   = 1'b1;
                    w_timeout_nxt = '0;
                    w_state_nxt   = S_FILL;
                end
            end
            S_FILL: begin
                if (r_count >= CW'(2)) begin
                    w_pop           = 1'b1;
                    w_hdr_phase_nxt = 1'b0;
                    w_state_nxt     = S_HDR0;
                end
            end
            S_HDR0: begin
                // Word0 is held for two cycles; the phase bit marks the second one
                if (r_hdr_phase) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_HDR1;
                end else begin
                    w_hdr_phase_nxt = 1'b1;
                end
            end
            S_HDR1: begin
                if (r_count != '0) begin
                    w_pop         = 1'b1;
                    w_timeout_nxt = '0;
                    w_state_nxt   = S_STREAM;
                end else begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_STREAM: begin
                // Loading-complete wins over a same-cycle packet handshake
                if (bus.Dec_Done_Loading) begin
                    w_timeout_nxt = '0;
                    w_state_nxt   = S_DONE;
                end else if (bus.Dec_Done_Packet) begin
                    w_timeout_nxt = '0;
                    if (r_count != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end else if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_timeout_nxt = r_timeout + TW'(1);
                end
            end
            S_DONE: begin
                w_discard   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_clear = w_start_acc | w_discard;
        w_push  = bus.CPU_Valid & r_cpu_ready;

        if (w_clear) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end

        // Ready depends only on the state and count it will be seen with
        w_ready_nxt = (w_state_nxt inside {S_FILL, S_HDR0, S_HDR1, S_STREAM}) &&
                      (w_count_nxt != CW'(FIFO_DEPTH));
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO storage
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.CPU_Data;
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cpu_ready    <= 1'b0;
            r_dec_bus      <= '0;
            r_dec_en       <= 1'b0;
            r_solver_start <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
            r_words        <= '0;
        end else begin
            r_cpu_ready    <= w_ready_nxt;
            r_dec_en       <= (w_state_nxt inside {S_HDR0, S_HDR1, S_STREAM});
            r_solver_start <= (w_state_nxt == S_DONE);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_error        <= (w_state_nxt == S_ERROR);
            if (w_pop) begin
                r_dec_bus <= r_mem[r_rd_ptr];
            end
            if (w_start_acc) begin
                r_words <= '0;
            end else if (w_pop && (r_words != '1)) begin
                r_words <= r_words + NW'(1);
            end
        end
    end

    assign bus.CPU_Ready          = r_cpu_ready;
    assign bus.Dec_Bus            = r_dec_bus;
    assign bus.Dec_Loading_Enable = r_dec_en;
    assign bus.Solver_Start       = r_solver_start;
    assign bus.Busy               = r_busy;
    assign bus.Error              = r_error;
    assign bus.Words_Loaded       = r_words;

endmodule

// File: tb/tb_load_sequencer.sv
// Purpose: self-checking bench for load_sequencer. Accepted CPU words are queued
// and compared against Dec_Bus whenever Words_Loaded shows a pop; timing, status
// and boundary behaviour are checked directly from the main sequence.
module tb_load_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic CLK = 1'b0;
    logic RST;

    load_sequencer_if bus();

    load_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks   = 0;
    int unsigned n_pass     = 0;
    int unsigned sol_pulses = 0;
    logic [31:0] exp_q[$];
    logic [15:0] prev_words = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare pops first (older words), then record new accepts
    always @(negedge CLK) begin
        if (!RST) begin
            prev_words = '0;
        end else begin
            if (bus.Words_Loaded == prev_words + 16'd1) begin
                if (exp_q.size() != 0) begin
                    check("sb_dec_bus", bus.Dec_Bus, exp_q.pop_front());
                end else begin
                    check("sb_pop_empty", 32'(bus.Words_Loaded), 32'(prev_words));
                end
            end
            prev_words = bus.Words_Loaded;
            if (bus.CPU_Valid && bus.CPU_Ready) begin
                exp_q.push_back(bus.CPU_Data);
            end
            if (bus.Solver_Start) begin
                sol_pulses++;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_load();
        exp_q.delete();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        bus.CPU_Valid = 1'b1;
        bus.CPU_Data  = d;
        step();
        bus.CPU_Valid = 1'b0;
    endtask

    // Push n (3..6) words right after Start; returns on the STREAM entry cycle
    task automatic to_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) push_word(base + 32'(i));
        steps(6 - n);
    endtask

    task automatic pulse_packet();
        bus.Dec_Done_Packet = 1'b1;
        step();
        bus.Dec_Done_Packet = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.CPU_Ready), 32'd0);
        check({tag, "_bus"},   bus.Dec_Bus, 32'd0);
        check({tag, "_en"},    32'(bus.Dec_Loading_Enable), 32'd0);
        check({tag, "_sol"},   32'(bus.Solver_Start), 32'd0);
        check({tag, "_busy"},  32'(bus.Busy), 32'd0);
        check({tag, "_err"},   32'(bus.Error), 32'd0);
        check({tag, "_words"}, 32'(bus.Words_Loaded), 32'd0);
    endtask

    initial begin
        RST                  = 1'b1;
        bus.Start            = 1'b0;
        bus.CPU_Data         = '0;
        bus.CPU_Valid        = 1'b0;
        bus.Dec_Done_Packet  = 1'b0;
        bus.Dec_Done_Loading = 1'b0;
        #2 RST = 1'b0;
        #1 check_reset_outputs("rst");
        steps(2);
        RST = 1'b1;
        step();
        check("idle_busy", 32'(bus.Busy), 32'd0);

        // Nominal load: 5, 3, then four payload words
        sol_pulses = 0;
        start_load();
        check("nom_busy", 32'(bus.Busy), 32'd1);
        check("nom_fill_ready", 32'(bus.CPU_Ready), 32'd1);
        push_word(32'd5);
        push_word(32'd3);
        push_word(32'hA000_0002);
        check("nom_hdr0_a", bus.Dec_Bus, 32'd5);
        check("nom_en", 32'(bus.Dec_Loading_Enable), 32'd1);
        push_word(32'hA000_0003);
        check("nom_hdr0_b", bus.Dec_Bus, 32'd5);
        push_word(32'hA000_0004);
        check("nom_hdr1", bus.Dec_Bus, 32'd3);
        push_word(32'hA000_0005);
        check("nom_word2", bus.Dec_Bus, 32'hA000_0002);
        for (int i = 0; i < 3; i++) begin
            pulse_packet();
            check("nom_pkt_next", bus.Dec_Bus, 32'hA000_0003 + 32'(i));
            step();
        end
        check("nom_words", 32'(bus.Words_Loaded), 32'd6);
        bus.Dec_Done_Loading = 1'b1;
        step();
        bus.Dec_Done_Loading = 1'b0;
        check("nom_solver", 32'(bus.Solver_Start), 32'd1);
        check("nom_done_en", 32'(bus.Dec_Loading_Enable), 32'd0);
        check("nom_done_busy", 32'(bus.Busy), 32'd1);
        step();
        check("nom_idle_busy", 32'(bus.Busy), 32'd0);
        check("nom_solver_off", 32'(bus.Solver_Start), 32'd0);
        check("nom_sol_pulses", sol_pulses, 32'd1);
        check("nom_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: CPU_Valid held, no decoder pops in STREAM
        sol_pulses = 0;
        start_load();
        bus.CPU_Valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.CPU_Data = 32'hB000_0000 + 32'(i);
            step();
        end
        check("bp_ready_low", 32'(bus.CPU_Ready), 32'd0);
        check("bp_fifo_words", 32'(exp_q.size()), 32'(DEPTH));
        bus.CPU_Data = 32'hB000_0007;
        step();
        check("bp_ready_held", 32'(bus.CPU_Ready), 32'd0);
        pulse_packet();
        check("bp_ready_reraise", 32'(bus.CPU_Ready), 32'd1);
        check("bp_words", 32'(bus.Words_Loaded), 32'd4);
        step();
        bus.CPU_Valid = 1'b0;
        check("bp_ready_full", 32'(bus.CPU_Ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pulse_packet();
            step();
        end
        bus.Dec_Done_Loading = 1'b1;
        step();
        bus.Dec_Done_Loading = 1'b0;
        step();
        check("bp_no_loss", 32'(exp_q.size()), 32'd0);
        check("bp_words_total", 32'(bus.Words_Loaded), 32'd8);
        check("bp_busy", 32'(bus.Busy), 32'd0);
        check("bp_sol_pulses", sol_pulses, 32'd1);

        // Header underrun: only two words, FIFO empty at end of HDR1
        start_load();
        push_word(32'hC000_0000);
        push_word(32'hC000_0001);
        steps(3);
        check("hdr1_err_before", 32'(bus.Error), 32'd0);
        check("hdr1_bus", bus.Dec_Bus, 32'hC000_0001);
        step();
        check("hdr1_err", 32'(bus.Error), 32'd1);
        check("hdr1_en", 32'(bus.Dec_Loading_Enable), 32'd0);

        // Start from ERROR, then stream underrun
        start_load();
        check("restart_err", 32'(bus.Error), 32'd0);
        check("restart_ready", 32'(bus.CPU_Ready), 32'd1);
        check("restart_words", 32'(bus.Words_Loaded), 32'd0);
        to_stream(32'hD000_0000, 3);
        check("ur_stream_bus", bus.Dec_Bus, 32'hD000_0002);
        check("ur_stream_err", 32'(bus.Error), 32'd0);
        pulse_packet();
        check("ur_err", 32'(bus.Error), 32'd1);
        check("ur_en", 32'(bus.Dec_Loading_Enable), 32'd0);
        check("ur_bus_held", bus.Dec_Bus, 32'hD000_0002);
        check("ur_ready", 32'(bus.CPU_Ready), 32'd0);
        check("ur_words", 32'(bus.Words_Loaded), 32'd3);

        // Timeout with no decoder activity
        start_load();
        to_stream(32'hE000_0000, 3);
        steps(TMO - 1);
        check("tmo_before", 32'(bus.Error), 32'd0);
        step();
        check("tmo_exact", 32'(bus.Error), 32'd1);

        // Timeout restarted by a packet at cycle 10
        start_load();
        to_stream(32'hF000_0000, 4);
        steps(9);
        pulse_packet();
        steps(6);
        check("tmo_rst_16", 32'(bus.Error), 32'd0);
        steps(9);
        check("tmo_rst_25", 32'(bus.Error), 32'd0);
        check("tmo_rst_words", 32'(bus.Words_Loaded), 32'd4);
        step();
        check("tmo_rst_26", 32'(bus.Error), 32'd1);

        // Start ignored in STREAM; Loading beats a same-cycle Packet
        sol_pulses = 0;
        start_load();
        to_stream(32'h1000_0000, 4);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        check("ign_start_words", 32'(bus.Words_Loaded), 32'd3);
        check("ign_start_en", 32'(bus.Dec_Loading_Enable), 32'd1);
        bus.Dec_Done_Packet  = 1'b1;
        bus.Dec_Done_Loading = 1'b1;
        step();
        bus.Dec_Done_Packet  = 1'b0;
        bus.Dec_Done_Loading = 1'b0;
        check("prio_solver", 32'(bus.Solver_Start), 32'd1);
        check("prio_words", 32'(bus.Words_Loaded), 32'd3);
        check("prio_bus", bus.Dec_Bus, 32'h1000_0002);
        step();
        check("prio_idle", 32'(bus.Busy), 32'd0);
        check("prio_sol_pulses", sol_pulses, 32'd1);
        exp_q.delete();

        // Asynchronous reset mid-STREAM
        start_load();
        to_stream(32'h2000_0000, 4);
        check("mid_busy", 32'(bus.Busy), 32'd1);
        #2 RST = 1'b0;
        #1 check_reset_outputs("async_rst");
        step();
        RST = 1'b1;
        exp_q.delete();
        step();
        check("post_rst_busy", 32'(bus.Busy), 32'd0);
        check("post_rst_ready", 32'(bus.CPU_Ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
